// File: rtl/las_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : las_ctrl_pkg
// Brief   : Shared state encodings, opcode/funct constants and control-word
//           field map for the load/add/sub multi-cycle controller.
// Revision: 1.0 - initial release
// ============================================================================
package las_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_MEMADDR = 3'd3,
        ST_MEMRD   = 3'd4,
        ST_EXEC    = 3'd5,
        ST_WB      = 3'd6,
        ST_HALT    = 3'd7
    } state_t;

    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;

    // Bit positions inside ctrl_word; multi-bit fields give their LSB.
    localparam int CW_PC_WE      = 0;
    localparam int CW_IR_WE      = 1;
    localparam int CW_IORD       = 2;
    localparam int CW_MEM_REQ    = 3;
    localparam int CW_MEM_TO_REG = 4;
    localparam int CW_REG_WE     = 5;
    localparam int CW_REG_DST    = 6;
    localparam int CW_ALU_SRC_A  = 7;
    localparam int CW_ALU_SRC_B  = 8;
    localparam int CW_ALU_OP     = 10;
    localparam int CW_PC_SRC     = 13;
    localparam int CW_A_WE       = 14;
    localparam int CW_B_WE       = 15;
    localparam int CW_ALUOUT_WE  = 16;
    localparam int CW_MDR_WE     = 17;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

    localparam logic [1:0] ALUSRCB_B    = 2'b00;
    localparam logic [1:0] ALUSRCB_4    = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM  = 2'b10;

    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] funct);
        return (op == OP_LW) ||
               ((op == OP_RTYPE) && ((funct == FN_ADD) || (funct == FN_SUB)));
    endfunction

endpackage
`default_nettype wire

// File: rtl/las_multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : las_multicycle_ctrl_if
// Brief   : Instruction/memory-handshake and control-word bundle between the
//           controller (slave) and its environment (master).
// Revision: 1.0 - initial release
// ============================================================================
interface las_multicycle_ctrl_if #(
    parameter int CTRL_W = 18,
    parameter int CNT_W  = 32
);
    logic              run;
    logic [31:0]       instr;
    logic              mem_ready;
    logic [CTRL_W-1:0] ctrl_word;
    logic [2:0]        state_o;
    logic              illegal;
    logic [CNT_W-1:0]  retired_cnt;
    logic [CNT_W-1:0]  cycle_cnt;

    modport master (
        output run, instr, mem_ready,
        input  ctrl_word, state_o, illegal, retired_cnt, cycle_cnt
    );

    modport slave (
        input  run, instr, mem_ready,
        output ctrl_word, state_o, illegal, retired_cnt, cycle_cnt
    );
endinterface
`default_nettype wire

// File: rtl/las_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module  : las_ctrl_decode
// Brief   : Moore control-word decode from FSM state; memory write strobes are
//           additionally qualified by mem_ready.
// Revision: 1.0 - initial release
// ============================================================================
module las_ctrl_decode
    import las_ctrl_pkg::*;
#(
    parameter int CTRL_W = 18
) (
    input  state_t            i_state,
    input  logic [5:0]        i_funct,
    input  logic              i_is_load,
    input  logic              i_mem_ready,
    output logic [CTRL_W-1:0] o_ctrl_word
);

    always_comb begin
        o_ctrl_word = '0;
        unique case (i_state)
            ST_FETCH: begin
                o_ctrl_word[CW_MEM_REQ]          = 1'b1;
                o_ctrl_word[CW_IORD]             = 1'b0;
                o_ctrl_word[CW_ALU_SRC_A]        = 1'b0;
                o_ctrl_word[CW_ALU_SRC_B +: 2]   = ALUSRCB_4;
                o_ctrl_word[CW_ALU_OP +: 3]      = ALU_ADD;
                o_ctrl_word[CW_PC_SRC]           = 1'b0;
                o_ctrl_word[CW_IR_WE]            = i_mem_ready;
                o_ctrl_word[CW_PC_WE]            = i_mem_ready;
            end
            ST_DECODE: begin
                o_ctrl_word[CW_A_WE]             = 1'b1;
                o_ctrl_word[CW_B_WE]             = 1'b1;
            end
            ST_MEMADDR: begin
                o_ctrl_word[CW_ALU_SRC_A]        = 1'b1;
                o_ctrl_word[CW_ALU_SRC_B +: 2]   = ALUSRCB_IMM;
                o_ctrl_word[CW_ALU_OP +: 3]      = ALU_ADD;
                o_ctrl_word[CW_ALUOUT_WE]        = 1'b1;
            end
            ST_MEMRD: begin
                o_ctrl_word[CW_MEM_REQ]          = 1'b1;
                o_ctrl_word[CW_IORD]             = 1'b1;
                o_ctrl_word[CW_MDR_WE]           = i_mem_ready;
            end
            ST_EXEC: begin
                o_ctrl_word[CW_ALU_SRC_A]        = 1'b1;
                o_ctrl_word[CW_ALU_SRC_B +: 2]   = ALUSRCB_B;
                o_ctrl_word[CW_ALU_OP +: 3]      = (i_funct == FN_SUB) ? ALU_SUB : ALU_ADD;
                o_ctrl_word[CW_ALUOUT_WE]        = 1'b1;
            end
            ST_WB: begin
                // Loads write MDR into rt; R-type writes ALUOut into rd.
                o_ctrl_word[CW_REG_WE]           = 1'b1;
                o_ctrl_word[CW_MEM_TO_REG]       = i_is_load;
                o_ctrl_word[CW_REG_DST]          = ~i_is_load;
            end
            default: begin
                o_ctrl_word = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/las_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : las_multicycle_ctrl
// Brief   : Multi-cycle fetch/decode/execute/memory/writeback sequencer for
//           LW, ADD and SUB. Optional counters: define LAS_PERF_CNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module las_multicycle_ctrl
    import las_ctrl_pkg::*;
#(
    parameter int CTRL_W = 18,
    parameter int CNT_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    las_multicycle_ctrl_if.slave  bus
);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_is_load;
    logic       r_illegal;
    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic       w_legal;

    assign w_op    = bus.instr[31:26];
    assign w_funct = bus.instr[5:0];
    assign w_legal = is_legal(w_op, w_funct);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:    if (bus.run)       w_state_nxt = ST_FETCH;
            ST_FETCH:   if (bus.mem_ready) w_state_nxt = ST_DECODE;
            ST_DECODE: begin
                if (!w_legal)              w_state_nxt = ST_HALT;
                else if (w_op == OP_LW)    w_state_nxt = ST_MEMADDR;
                else                       w_state_nxt = ST_EXEC;
            end
            ST_MEMADDR:                    w_state_nxt = ST_MEMRD;
            ST_MEMRD:   if (bus.mem_ready) w_state_nxt = ST_WB;
            ST_EXEC:                       w_state_nxt = ST_WB;
            ST_WB:                         w_state_nxt = ST_FETCH;
            ST_HALT:                       w_state_nxt = ST_HALT;
            default:                       w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_is_load <= 1'b0;
            r_illegal <= 1'b0;
        end else if (r_state == ST_DECODE) begin
            r_is_load <= (w_op == OP_LW);
            if (!w_legal) begin
                r_illegal <= 1'b1;
            end
        end
    end

    las_ctrl_decode #(
        .CTRL_W      (CTRL_W)
    ) u_decode (
        .i_state     (r_state),
        .i_funct     (w_funct),
        .i_is_load   (r_is_load),
        .i_mem_ready (bus.mem_ready),
        .o_ctrl_word (bus.ctrl_word)
    );

    assign bus.state_o = r_state;
    assign bus.illegal = r_illegal;

`ifdef LAS_PERF_CNT_EN
    logic [CNT_W-1:0] r_retired_cnt;
    logic [CNT_W-1:0] r_cycle_cnt;

    // Both counters wrap naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_retired_cnt <= '0;
            r_cycle_cnt   <= '0;
        end else begin
            if (r_state == ST_WB) begin
                r_retired_cnt <= r_retired_cnt + 1'b1;
            end
            if ((r_state != ST_IDLE) && (r_state != ST_HALT)) begin
                r_cycle_cnt <= r_cycle_cnt + 1'b1;
            end
        end
    end

    assign bus.retired_cnt = r_retired_cnt;
    assign bus.cycle_cnt   = r_cycle_cnt;
`else
    assign bus.retired_cnt = {CNT_W{1'b0}};
    assign bus.cycle_cnt   = {CNT_W{1'b0}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_las_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_las_multicycle_ctrl
// Brief   : Self-checking bench; a per-instruction cycle-sequence model drives
//           mem_ready and predicts state, control word, illegal and counters.
// Revision: 1.0 - initial release
// ============================================================================
module tb_las_multicycle_ctrl;

    localparam int CTRL_W = 18;
    localparam int CNT_W  = 32;

    // Expected control words, assembled by hand from the field map.
    localparam logic [17:0] W_IDLE      = 18'h00000;
    localparam logic [17:0] W_FETCH     = 18'h00908;
    localparam logic [17:0] W_FETCH_RDY = 18'h0090B;
    localparam logic [17:0] W_DECODE    = 18'h0C000;
    localparam logic [17:0] W_MEMADDR   = 18'h10A80;
    localparam logic [17:0] W_MEMRD     = 18'h0000C;
    localparam logic [17:0] W_MEMRD_RDY = 18'h2000C;
    localparam logic [17:0] W_EXEC_ADD  = 18'h10880;
    localparam logic [17:0] W_EXEC_SUB  = 18'h11880;
    localparam logic [17:0] W_WB_LOAD   = 18'h00030;
    localparam logic [17:0] W_WB_RTYPE  = 18'h00060;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    las_multicycle_ctrl_if #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();

    las_multicycle_ctrl #(
        .CTRL_W (CTRL_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_cyc = 0;
    logic [31:0] m_ret = 0;
    logic        m_ill = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs (rs = rst_n for the closing edge), then
    // compare the outputs of the state the model says we are in.
    task automatic cyc(input logic [2:0] st, input logic mr, input logic rn,
                       input logic rs, input logic [17:0] w);
        @(negedge clk);
        bus.mem_ready = mr;
        bus.run       = rn;
        rst_n         = rs;
        #1;
        chk("state",   {29'd0, bus.state_o}, {29'd0, st});
        chk("word",    {14'd0, bus.ctrl_word}, {14'd0, w});
        chk("illegal", {31'd0, bus.illegal}, {31'd0, m_ill});
`ifdef LAS_PERF_CNT_EN
        chk("retired", bus.retired_cnt, m_ret);
        chk("cycles",  bus.cycle_cnt, m_cyc);
`else
        chk("retired", bus.retired_cnt, 32'd0);
        chk("cycles",  bus.cycle_cnt, 32'd0);
`endif
        if (!rs) begin
            m_cyc = 0;
            m_ret = 0;
            m_ill = 1'b0;
        end else begin
            if (st != 3'd0 && st != 3'd7) m_cyc++;
            if (st == 3'd6) m_ret++;
        end
    endtask

    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    // Runs one instruction from its first FETCH cycle; for an illegal
    // opcode it stops after DECODE with the model marked as halted.
    task automatic run_instr(input logic [31:0] ins, input int fw, input int rw);
        logic [5:0] op;
        logic [5:0] fn;
        op = ins[31:26];
        fn = ins[5:0];
        bus.instr = ins;
        for (int k = 0; k < fw; k++) cyc(3'd1, 1'b0, rb(), 1'b1, W_FETCH);
        cyc(3'd1, 1'b1, rb(), 1'b1, W_FETCH_RDY);
        cyc(3'd2, rb(), rb(), 1'b1, W_DECODE);
        if (op == 6'h23) begin
            cyc(3'd3, rb(), rb(), 1'b1, W_MEMADDR);
            for (int k = 0; k < rw; k++) cyc(3'd4, 1'b0, rb(), 1'b1, W_MEMRD);
            cyc(3'd4, 1'b1, rb(), 1'b1, W_MEMRD_RDY);
            cyc(3'd6, rb(), rb(), 1'b1, W_WB_LOAD);
        end else if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22)) begin
            cyc(3'd5, rb(), rb(), 1'b1, (fn == 6'h22) ? W_EXEC_SUB : W_EXEC_ADD);
            cyc(3'd6, rb(), rb(), 1'b1, W_WB_RTYPE);
        end else begin
            m_ill = 1'b1;
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 2))
            0:       return {6'h23, r[25:0]};
            1:       return {6'h00, r[25:6], 6'h20};
            default: return {6'h00, r[25:6], 6'h22};
        endcase
    endfunction

    task automatic halt_and_reset(input logic [31:0] ins);
        run_instr(ins, 0, 0);
        for (int k = 0; k < 6; k++) cyc(3'd7, rb(), rb(), 1'b1, W_IDLE);
        cyc(3'd7, rb(), rb(), 1'b0, W_IDLE);
        cyc(3'd0, 1'b0, 1'b0, 1'b1, W_IDLE);
        cyc(3'd0, rb(), 1'b1, 1'b1, W_IDLE);
    endtask

    initial begin
        bus.run       = 1'b0;
        bus.instr     = 32'd0;
        bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);

        cyc(3'd0, 1'b0, 1'b0, 1'b0, W_IDLE);
        cyc(3'd0, 1'b1, 1'b0, 1'b1, W_IDLE);
        cyc(3'd0, 1'b0, 1'b0, 1'b1, W_IDLE);
        cyc(3'd0, 1'b0, 1'b1, 1'b1, W_IDLE);

        run_instr(32'h8C220004, 0, 0);
        run_instr(32'h00221820, 0, 0);
        run_instr(32'h00221822, 0, 0);
        @(posedge clk);
        #1;
`ifdef LAS_PERF_CNT_EN
        chk("perf_retired_3", bus.retired_cnt, 32'd3);
        chk("perf_cycles_13", bus.cycle_cnt, 32'd13);
`else
        chk("perf_retired_off", bus.retired_cnt, 32'd0);
        chk("perf_cycles_off", bus.cycle_cnt, 32'd0);
`endif

        run_instr(32'h00221820, 3, 0);

        for (int n = 0; n < 40; n++) begin
            run_instr(rand_instr(), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Reset while a data read is outstanding.
        bus.instr = 32'h8C220004;
        cyc(3'd1, 1'b1, rb(), 1'b1, W_FETCH_RDY);
        cyc(3'd2, 1'b0, rb(), 1'b1, W_DECODE);
        cyc(3'd3, 1'b0, rb(), 1'b1, W_MEMADDR);
        cyc(3'd4, 1'b0, rb(), 1'b1, W_MEMRD);
        cyc(3'd4, 1'b0, rb(), 1'b0, W_MEMRD);
        cyc(3'd0, 1'b0, 1'b0, 1'b1, W_IDLE);
        cyc(3'd0, 1'b0, 1'b1, 1'b1, W_IDLE);

        // Reset while an instruction fetch is outstanding.
        bus.instr = 32'h00221822;
        cyc(3'd1, 1'b0, rb(), 1'b1, W_FETCH);
        cyc(3'd1, 1'b0, rb(), 1'b0, W_FETCH);
        cyc(3'd0, 1'b1, 1'b0, 1'b1, W_IDLE);
        cyc(3'd0, 1'b0, 1'b1, 1'b1, W_IDLE);

        halt_and_reset(32'hFC000000);
        run_instr(rand_instr(), 1, 2);
        halt_and_reset(32'h00221821);

        for (int n = 0; n < 10; n++) begin
            run_instr(rand_instr(), $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
